// File: rtl/unidade_divisao_ex_pkg.sv
// ============================================================================
// Module   : unidade_divisao_ex_pkg
// Purpose  : Shared definitions for the EX-stage iterative divider: FSM state
//            encoding, default operand width and the quotient value returned
//            on division by zero.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package unidade_divisao_ex_pkg;

  // Default operand/result width of the divider.
  localparam int LARGURA_PADRAO = 32;

  // Quotient reported for a zero divisor at the default width (all ones).
  // Instances at other widths build the same pattern with '1.
  localparam logic [LARGURA_PADRAO-1:0] QUO_DIV_ZERO_PADRAO = '1;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    AJUSTE = 2'b10,
    FIM    = 2'b11
  } estado_t;

endpackage : unidade_divisao_ex_pkg

`default_nettype wire

// File: rtl/unidade_divisao_ex_passo.sv
// ============================================================================
// Module   : passo_divisao
// Purpose  : One restoring radix-2 division step (purely combinational).
//            Shifts {remainder, quotient} left by one, trial-subtracts the
//            divisor and keeps the difference when it does not borrow.
// Ports    : remParcial  - partial remainder before the step
//            quoParcial  - partial quotient / remaining dividend bits
//            divisor     - (absolute) divisor
//            remProx     - partial remainder after the step
//            quoProx     - partial quotient after the step
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module passo_divisao
  import unidade_divisao_ex_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic [LARGURA-1:0] remParcial,
  input  logic [LARGURA-1:0] quoParcial,
  input  logic [LARGURA-1:0] divisor,
  output logic [LARGURA-1:0] remProx,
  output logic [LARGURA-1:0] quoProx
);

  // One extra bit: the shifted remainder can reach 2*divisor-1, which does
  // not fit in LARGURA bits for large unsigned divisors. Because the shifted
  // value is always below 2*divisor, the MSB of the difference is a clean
  // borrow flag.
  logic [LARGURA:0] w_remDesloc;
  logic [LARGURA:0] w_diferenca;

  assign w_remDesloc = {remParcial, quoParcial[LARGURA-1]};
  assign w_diferenca = w_remDesloc - {1'b0, divisor};

  always_comb begin
    remProx = w_remDesloc[LARGURA-1:0];
    quoProx = {quoParcial[LARGURA-2:0], 1'b0};
    if (!w_diferenca[LARGURA]) begin
      remProx    = w_diferenca[LARGURA-1:0];
      quoProx[0] = 1'b1;
    end
  end

endmodule : passo_divisao

`default_nettype wire

// File: rtl/unidade_divisao_ex.sv
// ============================================================================
// Module   : unidade_divisao_ex
// Purpose  : Iterative multi-cycle integer divider beside the EX stage.
//            Signed (DIV) and unsigned (DIVU) division of the forwarded RS/RT
//            values; stalls the pipeline through `busy` until the result is
//            ready and pulses `valid` for one cycle with the registered
//            quotient/remainder.
// Ports    : Clock      - pipeline clock (rising edge)
//            Reset_n    - synchronous active-low reset
//            start      - DIV instruction present in EX (sampled in IDLE)
//            sinal      - 1 = signed, 0 = unsigned (captured with start)
//            dividendo  - forwarded RS value
//            divisor    - forwarded RT value
//            flush      - abort current operation
//            busy       - stall request to the hazard unit
//            valid      - one-cycle result strobe
//            quociente  - registered quotient
//            resto      - registered remainder
//            div_zero   - registered divide-by-zero flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unidade_divisao_ex
  import unidade_divisao_ex_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               sinal,
  input  logic [LARGURA-1:0] dividendo,
  input  logic [LARGURA-1:0] divisor,
  input  logic               flush,
  output logic               busy,
  output logic               valid,
  output logic [LARGURA-1:0] quociente,
  output logic [LARGURA-1:0] resto,
  output logic               div_zero
);

  localparam int                 CONT_W     = $clog2(LARGURA + 1);
  localparam logic [LARGURA-1:0] c_QUO_ZERO = '1;

  estado_t            r_estado;
  logic [CONT_W-1:0]  r_contador;
  logic [LARGURA-1:0] r_rem;
  logic [LARGURA-1:0] r_quo;
  logic [LARGURA-1:0] r_divisor;
  logic               r_negQuo;
  logic               r_negRem;

  logic               w_divisorZero;
  logic               w_dividendoNeg;
  logic               w_divisorNeg;
  logic [LARGURA-1:0] w_absDividendo;
  logic [LARGURA-1:0] w_absDivisor;
  logic [LARGURA-1:0] w_remProx;
  logic [LARGURA-1:0] w_quoProx;

  assign w_divisorZero  = (divisor == '0);
  assign w_dividendoNeg = sinal & dividendo[LARGURA-1];
  assign w_divisorNeg   = sinal & divisor[LARGURA-1];
  // For the most negative value the negation wraps back onto itself, which
  // is the correct unsigned magnitude 2^(LARGURA-1).
  assign w_absDividendo = w_dividendoNeg ? -dividendo : dividendo;
  assign w_absDivisor   = w_divisorNeg   ? -divisor   : divisor;

  passo_divisao #(
    .LARGURA (LARGURA)
  ) u_passo (
    .remParcial (r_rem),
    .quoParcial (r_quo),
    .divisor    (r_divisor),
    .remProx    (w_remProx),
    .quoProx    (w_quoProx)
  );

  // The start term lets the stall begin in the very cycle the DIV sits in EX,
  // before the FSM has left IDLE.
  always_comb begin
    busy = 1'b0;
    case (r_estado)
      CALC, AJUSTE: busy = 1'b1;
      IDLE:         busy = start & ~flush;
      default:      busy = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_estado   <= IDLE;
      r_contador <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_negQuo   <= 1'b0;
      r_negRem   <= 1'b0;
      valid      <= 1'b0;
      quociente  <= '0;
      resto      <= '0;
      div_zero   <= 1'b0;
    end else begin
      case (r_estado)
        IDLE: begin
          valid <= 1'b0;
          if (start && !flush) begin
            if (w_divisorZero) begin
              // Fast path: result is known immediately.
              quociente <= c_QUO_ZERO;
              resto     <= dividendo;
              div_zero  <= 1'b1;
              valid     <= 1'b1;
              r_estado  <= FIM;
            end else begin
              r_rem      <= '0;
              r_quo      <= w_absDividendo;
              r_divisor  <= w_absDivisor;
              r_contador <= CONT_W'(LARGURA);
              r_negQuo   <= w_dividendoNeg ^ w_divisorNeg;
              r_negRem   <= w_dividendoNeg;
              r_estado   <= CALC;
            end
          end
        end

        CALC: begin
          if (flush) begin
            r_estado <= IDLE;
          end else begin
            r_rem      <= w_remProx;
            r_quo      <= w_quoProx;
            r_contador <= r_contador - CONT_W'(1);
            if (r_contador == CONT_W'(1)) begin
              r_estado <= AJUSTE;
            end
          end
        end

        AJUSTE: begin
          if (flush) begin
            r_estado <= IDLE;
          end else begin
            // Sign flags are only ever set for signed operations, so the
            // unsigned case passes straight through.
            quociente <= r_negQuo ? -r_quo : r_quo;
            resto     <= r_negRem ? -r_rem : r_rem;
            div_zero  <= 1'b0;
            valid     <= 1'b1;
            r_estado  <= FIM;
          end
        end

        FIM: begin
          valid    <= 1'b0;
          r_estado <= IDLE;
        end

        default: begin
          valid    <= 1'b0;
          r_estado <= IDLE;
        end
      endcase
    end
  end

endmodule : unidade_divisao_ex

`default_nettype wire

// File: tb/tb_unidade_divisao_ex.sv
// ============================================================================
// Module   : tb_unidade_divisao_ex
// Purpose  : Self-checking bench for unidade_divisao_ex (LARGURA = 32).
//            Expected results come from a plain-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unidade_divisao_ex;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         Clock;
  logic         Reset_n;
  logic         start;
  logic         sinal;
  logic [W-1:0] dividendo;
  logic [W-1:0] divisor;
  logic         flush;
  logic         busy;
  logic         valid;
  logic [W-1:0] quociente;
  logic [W-1:0] resto;
  logic         div_zero;

  int nChecks = 0;
  int nErrors = 0;

  unidade_divisao_ex #(.LARGURA(W)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .start     (start),
    .sinal     (sinal),
    .dividendo (dividendo),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .valid     (valid),
    .quociente (quociente),
    .resto     (resto),
    .div_zero  (div_zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: 64-bit arithmetic so the signed overflow case wraps
  // naturally; SV division truncates toward zero.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint sa, sb, qq, rr;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; dz = 1'b0;
    end else begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      qq = sa / sb; rr = sa % sb;
      q = qq[W-1:0]; r = rr[W-1:0]; dz = 1'b0;
    end
  endtask

  // Drives one operation from IDLE and waits (bounded) for valid.
  // Cycle 0 is the start cycle; lat is the cycle in which valid was seen
  // (-1 on timeout). busyErr counts cycles where busy disagreed with
  // "high from start up to, not including, the valid cycle".
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output int lat, output int busyErr,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    @(negedge Clock);
    dividendo = a; divisor = b; sinal = s; start = 1'b1;
    #1;
    busyErr = 0; lat = -1; q = 'x; r = 'x; dz = 1'bx;
    if (busy !== 1'b1) busyErr++;
    @(negedge Clock);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (valid === 1'b1) begin
        lat = c; q = quociente; r = resto; dz = div_zero;
        if (busy !== 1'b0) busyErr++;
        break;
      end
      if (busy !== 1'b1) busyErr++;
      @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; start = 1'b0; flush = 1'b0; sinal = 1'b0;
    dividendo = '0; divisor = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    nChecks++;
    if ({busy, valid, quociente, resto, div_zero} !== '0) begin
      nErrors++;
      $display("FAIL reset_state: got busy=%b valid=%b q=%h r=%h dz=%b, want all 0",
               busy, valid, quociente, resto, div_zero);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] a [5] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'h80000000};
    logic [W-1:0] b [5] = '{32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic         s [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] eq [5] = '{32'd14, 32'hFFFFFFFD, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] er [5] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd0};
    logic         ez [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int           el [5] = '{LAT, LAT, LAT, 1, LAT};
    int lat, be;
    logic [W-1:0] q, r;
    logic dz;
    for (int i = 0; i < 5; i++) begin
      do_op(a[i], b[i], s[i], lat, be, q, r, dz);
      nChecks++;
      if (lat != el[i] || be != 0) begin
        nErrors++;
        $display("FAIL directed%0d_timing: got lat=%0d busyErr=%0d, want lat=%0d busyErr=0",
                 i, lat, be, el[i]);
      end
      nChecks++;
      if (q !== eq[i] || r !== er[i] || dz !== ez[i]) begin
        nErrors++;
        $display("FAIL directed%0d_result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                 i, q, r, dz, eq[i], er[i], ez[i]);
      end
      @(negedge Clock);
      nChecks++;
      if (valid !== 1'b0) begin
        nErrors++;
        $display("FAIL directed%0d_pulse: valid=%b one cycle after strobe, want 0", i, valid);
      end
    end
  endtask

  task automatic test_flush();
    int lat, be;
    logic [W-1:0] q, r, pq, pr;
    logic dz, pz;
    ref_div(32'd50, 32'd6, 1'b0, pq, pr, pz);
    do_op(32'd50, 32'd6, 1'b0, lat, be, q, r, dz);
    nChecks++;
    if (q !== pq || r !== pr || dz !== pz || lat != LAT) begin
      nErrors++;
      $display("FAIL flush_setup: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
               q, r, dz, lat, pq, pr, pz, LAT);
    end
    // 100/7 started at cycle 0, flushed during cycle 10.
    @(negedge Clock);
    dividendo = 32'd100; divisor = 32'd7; sinal = 1'b0; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    repeat (9) @(negedge Clock);
    flush = 1'b1;
    @(negedge Clock);
    flush = 1'b0;
    #1;
    nChecks++;
    if (busy !== 1'b0 || valid !== 1'b0 || quociente !== pq || resto !== pr || div_zero !== pz) begin
      nErrors++;
      $display("FAIL flush_abort: got busy=%b valid=%b q=%h r=%h dz=%b, want busy=0 valid=0 q=%h r=%h dz=%b",
               busy, valid, quociente, resto, div_zero, pq, pr, pz);
    end
    // New op starts at cycle 12; valid expected at cycle 46.
    do_op(32'd9, 32'd3, 1'b0, lat, be, q, r, dz);
    nChecks++;
    if (lat != LAT || be != 0 || q !== 32'd3 || r !== 32'd0 || dz !== 1'b0) begin
      nErrors++;
      $display("FAIL flush_restart: got lat=%0d busyErr=%0d q=%h r=%h, want lat=%0d busyErr=0 q=3 r=0",
               lat, be, q, r, LAT);
    end
    // flush together with start in IDLE: must stay idle.
    @(negedge Clock);
    dividendo = 32'd20; divisor = 32'd4; start = 1'b1; flush = 1'b1;
    #1;
    be = (busy !== 1'b0) ? 1 : 0;
    @(negedge Clock);
    start = 1'b0; flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy !== 1'b0 || valid !== 1'b0) be++;
      @(negedge Clock);
    end
    nChecks++;
    if (be != 0 || quociente !== 32'd3) begin
      nErrors++;
      $display("FAIL flush_start_idle: got %0d busy/valid cycles q=%h, want 0 and q=3", be, quociente);
    end
  endtask

  task automatic test_reset_mid();
    int lat, be;
    logic [W-1:0] q, r;
    logic dz;
    // start pulses with other operands during CALC must be ignored.
    @(negedge Clock);
    dividendo = 32'd100; divisor = 32'd7; sinal = 1'b0; start = 1'b1;
    #1;
    be = (busy !== 1'b1) ? 1 : 0;
    lat = -1;
    @(negedge Clock);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (valid === 1'b1) begin lat = c; q = quociente; r = resto; break; end
      if (c == 5 || c == 9) begin
        dividendo = 32'd1000; divisor = 32'd3; sinal = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge Clock);
    end
    start = 1'b0;
    nChecks++;
    if (lat != LAT || be != 0 || q !== 32'd14 || r !== 32'd2) begin
      nErrors++;
      $display("FAIL start_in_calc: got lat=%0d q=%h r=%h, want lat=%0d q=14 r=2", lat, q, r, LAT);
    end
    // Reset during cycle 20 of a running operation.
    @(negedge Clock);
    dividendo = 32'd77; divisor = 32'd5; sinal = 1'b0; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    repeat (19) @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    nChecks++;
    if ({busy, valid, quociente, resto, div_zero} !== '0) begin
      nErrors++;
      $display("FAIL reset_mid: got busy=%b valid=%b q=%h r=%h dz=%b, want all 0",
               busy, valid, quociente, resto, div_zero);
    end
    do_op(32'd77, 32'd5, 1'b0, lat, be, q, r, dz);
    nChecks++;
    if (lat != LAT || be != 0 || q !== 32'd15 || r !== 32'd2 || dz !== 1'b0) begin
      nErrors++;
      $display("FAIL after_reset: got lat=%0d q=%h r=%h dz=%b, want lat=%0d q=15 r=2 dz=0",
               lat, q, r, dz, LAT);
    end
  endtask

  task automatic test_random();
    int lat, be, el;
    logic [W-1:0] a, b, q, r, eq, er;
    logic s, dz, ez;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 15));
        3:       begin a = 32'h80000000; b = $urandom_range(0, 1) ? 32'hFFFFFFFF : 32'd1; end
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      ref_div(a, b, s, eq, er, ez);
      el = (b == 0) ? 1 : LAT;
      do_op(a, b, s, lat, be, q, r, dz);
      nChecks++;
      if (lat != el || be != 0 || q !== eq || r !== er || dz !== ez) begin
        nErrors++;
        $display("FAIL random%0d %h/%h s=%b: got q=%h r=%h dz=%b lat=%0d busyErr=%0d, want q=%h r=%h dz=%b lat=%0d",
                 i, a, b, s, q, r, dz, lat, be, eq, er, ez, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule : tb_unidade_divisao_ex

`default_nettype wire

// File: doc/unidade_divisao_ex.md
Name: unidade_divisao_ex

Overview:
- Iterative multi-cycle integer divider beside the EX stage, driven by the decoded DIV opcode.
- Consumes the forwarded RS/RT operands that EX already selects.
- Produces quotient and remainder for the EX/MEM register.
- Raises `busy` so the hazard unit holds PC, IF/ID and ID/EX until the result is ready.

Parameters:
- LARGURA, 32, operand and result width in bits (≥4).

Ports:
- Clock  input  1  pipeline clock, all state updates on rising edge
- Reset_n  input  1  synchronous, active-low reset
- start  input  1  EX holds a DIV instruction; sampled only in IDLE
- sinal  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start
- dividendo  input  LARGURA  forwarded RS value
- divisor  input  LARGURA  forwarded RT value
- flush  input  1  abort current operation (branch/IF flush)
- busy  output  1  stall request to the hazard unit
- valid  output  1  one-cycle pulse: results available this cycle
- quociente  output  LARGURA  registered quotient
- resto  output  LARGURA  registered remainder
- div_zero  output  1  registered; set with valid when divisor was 0

Behaviour:
- Reset (Reset_n=0 at an edge), from any state: state=IDLE; busy=0, valid=0, quociente=0, resto=0, div_zero=0; internal counter and registers cleared.
- State machine: IDLE, CALC, AJUSTE, FIM.
- IDLE → CALC when start=1 and flush=0 and divisor≠0.
  - Captures |dividendo| and |divisor| when sinal=1, raw values otherwise.
  - Records sign of quotient (xor of operand signs) and sign of dividend.
  - Counter=LARGURA; partial remainder=0.
- IDLE → FIM when start=1, flush=0 and divisor=0 (fast path).
  - quociente = all ones.
  - resto = dividendo unchanged.
  - div_zero=1.
- CALC performs one restoring radix-2 step per edge:
  - Shift {rem,quo} left 1.
  - Trial subtract divisor; if no borrow, keep the difference and set quo LSB=1.
  - Counter decrements; after the LARGURA-th step → AJUSTE.
- AJUSTE (signed only; unsigned passes values through):
  - Negate quotient if the quotient sign is 1.
  - Negate remainder if the dividend sign is 1.
  - Remainder sign follows dividend; quotient truncates toward zero.
  - Results are registered into quociente/resto; div_zero=0; → FIM.
- FIM: valid=1 for exactly this cycle; → IDLE on next edge.
- Latency: start sampled at edge k ⇒ valid high during the cycle after edge k+LARGURA+1 (34 cycles for LARGURA=32). Divide-by-zero: valid the cycle after edge k.
- busy = 1 in CALC and AJUSTE; 0 in IDLE and FIM, so the pipeline advances in the same cycle valid is high.
- Combinational busy also asserts in IDLE when start=1 and flush=0, so the stall begins with the start cycle.
- Outputs quociente/resto/div_zero hold their last value until the next FIM; valid is never asserted outside FIM.
- Signed overflow: 0x8000_0000 / -1 yields quociente=0x8000_0000, resto=0 (two's-complement wrap), div_zero=0, normal latency.
- start while not IDLE: ignored; operands are not resampled.
- flush in CALC/AJUSTE: → IDLE next edge; no valid; result registers keep their previous values.
- flush and start together in IDLE: flush wins; stays IDLE.
- flush in FIM: valid still pulses (result already committed); → IDLE.
- Reset takes priority over flush and start.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, CALC=2'b01, AJUSTE=2'b10, FIM=2'b11), default LARGURA, and the div-by-zero quotient constant (all ones).
- One natural combinational sub-module, `passo_divisao`:
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder and next quotient for one restoring step.
- Sign handling and the FSM stay in the top.

Test Plan:
- Unsigned 100/7, start at cycle 0 → busy 1 for cycles 0–33; valid at cycle 34; quociente=14, resto=2, div_zero=0.
- Signed -7/2 (0xFFFFFFF9, 0x2) → quociente=0xFFFFFFFD (-3), resto=0xFFFFFFFF (-1) at cycle 34. Also check unsigned 0xFFFFFFF9/2 → 0x7FFFFFFC, resto=1.
- Divide by zero: 5/0, sinal=1 → valid at cycle 1; quociente=0xFFFFFFFF, resto=5, div_zero=1; busy high only in cycle 0.
- Overflow 0x80000000 / 0xFFFFFFFF signed → quociente=0x80000000, resto=0, div_zero=0.
- flush at cycle 10 of a 100/7 operation → busy 0 from cycle 11; no valid pulse; outputs keep prior values. A new start at cycle 12 of 9/3 → valid at cycle 46 with quociente=3, resto=0.
- Reset_n=0 at cycle 20 mid-operation, plus start pulses during CALC → all outputs 0 after the reset edge; state IDLE; mid-CALC start pulses never alter the running result.
